// File: rtl/puf_challenge_sequencer_if.sv
// Bundles the host-side control and RO-PUF core signals of the challenge
// sequencer. The sequencer connects through the slave modport. The host/core
// side, or a testbench standing in for both, connects through master.
//
// Handshake: the sequencer accepts a start pulse only while idle (busy=0).
// From the cycle after acceptance, busy stays high through the done cycle.
// done is a one-cycle pulse; response/hd/pass are valid in that cycle and
// are held afterwards. start is not queued while busy.
interface puf_challenge_sequencer_if #(
   parameter int N_BITS = 16
) ();
   localparam int HD_W = $clog2(N_BITS + 1);

   logic              start;
   logic [3:0]        challenge;
   logic [N_BITS-1:0] golden;
   logic              puf_bit;
   logic [3:0]        sel_a;
   logic [3:0]        sel_b;
   logic              ro_enable;
   logic              ro_reset;
   logic              busy;
   logic              done;
   logic [N_BITS-1:0] response;
   logic [HD_W-1:0]   hd;
   logic              pass;
   logic [2:0]        state_dbg;

   modport master (
      output start, challenge, golden, puf_bit,
      input  sel_a, sel_b, ro_enable, ro_reset, busy, done, response, hd, pass,
             state_dbg
   );

   modport slave (
      input  start, challenge, golden, puf_bit,
      output sel_a, sel_b, ro_enable, ro_reset, busy, done, response, hd, pass,
             state_dbg
   );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// RO-PUF challenge sequencer. It steps the core through N_BITS ring pairs.
// Each pair goes through settle (RO reset), measure (RO enable), hold and
// capture. The sequencer assembles the comparator bits LSB first.
// Optional feature macro: PUF_HD_CHECK_EN adds a Hamming-distance check
// against the golden word. Without the macro, hd and pass read 0.
// Every output comes from a register or is decoded from the state register.
module puf_challenge_sequencer #(
   parameter int N_BITS        = 16,
   parameter int SETTLE_CYCLES = 3,
   parameter int MEAS_CYCLES   = 4095,
   parameter int HD_THRESH     = 3
) (
   input logic                    clock,
   input logic                    reset,
   puf_challenge_sequencer_if.slave bus
);
   localparam int HD_W = $clog2(N_BITS + 1);
   localparam int KW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETTLE  = 3'd1,
      S_MEASURE = 3'd2,
      S_HOLD    = 3'd3,
      S_CAPTURE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [11:0]       timer_q, timer_d;
   logic [KW-1:0]     k_q, k_d;
   logic [3:0]        sel_a_q, sel_a_d;
   logic [3:0]        sel_b_q, sel_b_d;
   logic [N_BITS-1:0] response_q, response_d;
   logic [N_BITS-1:0] resp_cap;
   logic              last_pair;
   logic              accept;

   assign accept    = (state_q == S_IDLE) && bus.start;
   assign last_pair = (k_q == KW'(N_BITS - 1));

   // Response word with the current pair's comparator bit merged in
   always_comb begin
      resp_cap       = response_q;
      resp_cap[k_q]  = bus.puf_bit;
   end

   // Next-state, timer, pair index, selects and response assembly
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      k_d        = k_q;
      sel_a_d    = sel_a_q;
      sel_b_d    = sel_b_q;
      response_d = response_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_SETTLE;
               timer_d    = 12'(SETTLE_CYCLES);
               k_d        = '0;
               sel_a_d    = bus.challenge;
               sel_b_d    = bus.challenge + 4'd1;
               response_d = '0;
            end
         end
         S_SETTLE: begin
            if (timer_q == 12'd1) begin
               state_d = S_MEASURE;
               timer_d = 12'(MEAS_CYCLES);
            end else begin
               timer_d = timer_q - 12'd1;
            end
         end
         S_MEASURE: begin
            if (timer_q == 12'd1) begin
               state_d = S_HOLD;
               timer_d = 12'd1;
            end else begin
               timer_d = timer_q - 12'd1;
            end
         end
         S_HOLD: begin
            state_d = S_CAPTURE;
            timer_d = 12'd1;
         end
         S_CAPTURE: begin
            response_d = resp_cap;
            if (last_pair) begin
               state_d = S_DONE;
               timer_d = 12'd1;
            end else begin
               // 4-bit wrap keeps sel_a and sel_b distinct on every pair
               state_d = S_SETTLE;
               timer_d = 12'(SETTLE_CYCLES);
               k_d     = k_q + KW'(1);
               sel_a_d = sel_a_q + 4'd1;
               sel_b_d = sel_b_q + 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            timer_d = 12'd0;
         end
         default: begin
            state_d = S_IDLE;
            timer_d = 12'd0;
         end
      endcase
   end

   // State and datapath registers with asynchronous abort on reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         timer_q    <= 12'd0;
         k_q        <= '0;
         sel_a_q    <= 4'd0;
         sel_b_q    <= 4'd0;
         response_q <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         k_q        <= k_d;
         sel_a_q    <= sel_a_d;
         sel_b_q    <= sel_b_d;
         response_q <= response_d;
      end
   end

`ifdef PUF_HD_CHECK_EN
   logic [HD_W-1:0] hd_calc;
   logic [HD_W-1:0] hd_q, hd_d;
   logic            pass_q, pass_d;

   // Popcount of the final response against the enrolled golden word
   always_comb begin
      hd_calc = '0;
      for (int i = 0; i < N_BITS; i++) begin
         hd_calc = hd_calc + HD_W'(resp_cap[i] ^ bus.golden[i]);
      end
   end

   // hd/pass update on the last capture and clear on start acceptance
   always_comb begin
      hd_d   = hd_q;
      pass_d = pass_q;
      if (accept) begin
         hd_d   = '0;
         pass_d = 1'b0;
      end else if ((state_q == S_CAPTURE) && last_pair) begin
         hd_d   = hd_calc;
         pass_d = (int'(hd_calc) <= HD_THRESH);
      end
   end

   // Hamming-distance result registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hd_q   <= '0;
         pass_q <= 1'b0;
      end else begin
         hd_q   <= hd_d;
         pass_q <= pass_d;
      end
   end

   assign bus.hd   = hd_q;
   assign bus.pass = pass_q;
`else
   assign bus.hd   = '0;
   assign bus.pass = 1'b0;
`endif

   assign bus.sel_a     = sel_a_q;
   assign bus.sel_b     = sel_b_q;
   assign bus.ro_enable = (state_q == S_MEASURE);
   assign bus.ro_reset  = (state_q == S_IDLE) || (state_q == S_SETTLE) ||
                          (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.response  = response_q;
   assign bus.state_dbg = state_q;
endmodule
